// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; base ops registered with latency 1, RV32M ops iterate radix-2 for WIDTH+1 cycles.
// Holds result while out_valid && !out_ready; `SEQ_ALU_MULDIV_EN enables the M datapath (otherwise M ops return 0).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

`ifdef SEQ_ALU_MULDIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd3} state_t;
`endif

    state_t           state, state_nxt;
    logic             accept;
    logic             go_iter;
    logic [WIDTH-1:0] base_res, imm_res;

    always_comb begin
        base_res = '0;
        case (op[3:0])
            4'b0000: base_res = data_a + data_b;
            4'b1000: base_res = data_a - data_b;
            4'b0001: base_res = data_a << data_b[SHW-1:0];
            4'b0010: base_res = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(data_b)};
            4'b0011: base_res = {{(WIDTH-1){1'b0}}, data_a < data_b};
            4'b0100: base_res = data_a ^ data_b;
            4'b0101: base_res = data_a >> data_b[SHW-1:0];
            4'b1101: base_res = $signed(data_a) >>> data_b[SHW-1:0];
            4'b0110: base_res = data_a | data_b;
            4'b0111: base_res = data_a & data_b;
            4'b1110: base_res = data_a;
            4'b1111: base_res = data_b;
            default: base_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   LAST = SHW'(WIDTH - 1);

    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   opnd, hi, lo, hi_nxt, lo_nxt;
    logic               neg;
    logic [2:0]         mop;
    logic               sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, fin_res;

    // Divide-by-zero and signed overflow finish immediately instead of iterating.
    always_comb begin
        imm_res = base_res;
        go_iter = 1'b0;
        if (op[4]) begin
            imm_res = '0;
            if (!op[2])
                go_iter = 1'b1;
            else if (data_b == '0)
                imm_res = op[1] ? data_a : '1;
            else if (!op[0] && data_a == SMIN && data_b == '1)
                imm_res = op[1] ? '0 : data_a;
            else
                go_iter = 1'b1;
        end
    end

    always_comb begin
        sgn_a = data_a[WIDTH-1] && (op[2:0] inside {3'b001, 3'b010, 3'b100, 3'b110});
        sgn_b = data_b[WIDTH-1] && (op[2:0] inside {3'b001, 3'b100, 3'b110});
        mag_a = sgn_a ? -data_a : data_a;
        mag_b = sgn_b ? -data_b : data_b;
    end

    // {hi,lo} is the shifting product for multiply, {remainder,quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, {WIDTH{lo[0]}} & opnd};
        div_trial = {hi, lo[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd};
        if (!mop[2]) begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            hi_nxt = div_diff[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nxt = div_trial[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
        end
        prod_fix = neg ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
        q_fix    = neg ? -lo_nxt : lo_nxt;
        r_fix    = neg ? -hi_nxt : hi_nxt;
        if (!mop[2])
            fin_res = (mop[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        else
            fin_res = mop[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            opnd <= '0;
            hi   <= '0;
            lo   <= '0;
            neg  <= 1'b0;
            mop  <= '0;
        end else if (accept) begin
            cnt  <= '0;
            mop  <= op[2:0];
            neg  <= (op[2] && op[1]) ? sgn_a : (sgn_a ^ sgn_b);
            hi   <= '0;
            opnd <= op[2] ? mag_b : mag_a;
            lo   <= op[2] ? mag_a : mag_b;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_nxt;
            lo  <= lo_nxt;
        end
    end
`else
    always_comb begin
        imm_res = op[4] ? '0 : base_res;
        go_iter = 1'b0;
    end
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready)
                    state_nxt = IDLE;
            end
`ifdef SEQ_ALU_MULDIV_EN
            MUL, DIV: begin
                busy = 1'b1;
                if (cnt == LAST)
                    state_nxt = DONE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) begin
            state_nxt = DONE;
`ifdef SEQ_ALU_MULDIV_EN
            if (go_iter)
                state_nxt = op[2] ? DIV : MUL;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            result <= '0;
        else if (accept && !go_iter)
            result <= imm_res;
`ifdef SEQ_ALU_MULDIV_EN
        else if (busy && cnt == LAST)
            result <= fin_res;
`endif
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu: driver pushes expected result/latency, monitor checks on each output transfer.
module tb_seq_alu;

`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int ILAT = MD ? 33 : 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] data_a, data_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;

    logic [31:0] val_q[$];
    int          lat_q[$];
    int          acc_q[$];
    string       name_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] mexp(input logic [31:0] v);
        return MD ? v : 32'h0;
    endfunction

    // Monitor: latency on first sight of out_valid, value on each transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                seen = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (out_valid) begin
                    if (!seen && lat_q.size() > 0)
                        chk({"lat_", name_q[0]}, cyc - acc_q[0], lat_q[0]);
                    seen = 1'b1;
                    if (out_ready) begin
                        if (val_q.size() == 0) begin
                            checks++;
                            $display("FAIL spurious_output: result %h with nothing expected", result);
                        end else begin
                            chk(name_q[0], result, val_q[0]);
                            void'(val_q.pop_front());
                            void'(lat_q.pop_front());
                            void'(acc_q.pop_front());
                            void'(name_q.pop_front());
                        end
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ev, input int lat, input string nm, output int waited);
        waited = 0;
        in_valid = 1'b1;
        op = o;
        data_a = a;
        data_b = b;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL %s accept_timeout: in_ready 0 after %0d cycles, required 1", nm, waited);
        end else begin
            val_q.push_back(ev);
            lat_q.push_back(lat);
            acc_q.push_back(cyc);
            name_q.push_back(nm);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op = 5'($urandom);
        data_a = $urandom;
        data_b = $urandom;
    endtask

    task automatic drain(input string nm);
        int w = 0;
        while ((val_q.size() != 0 || out_valid) && w < 200) begin
            @(negedge clk);
            #3;
            w++;
        end
        if (val_q.size() != 0 || out_valid) begin
            checks++;
            $display("FAIL %s drain_timeout: %0d results outstanding, required 0", nm, val_q.size());
        end
        @(negedge clk);
    endtask

    logic [4:0]  t_op[14];
    logic [31:0] t_a[14], t_b[14], t_e[14];
    logic [4:0]  m_op[9];
    logic [31:0] m_a[9], m_b[9], m_e[9];
    bit          m_it[9];

    initial begin
        int w1, w2, w3, wd;
        t_op = '{5'b01000, 5'b00001, 5'b00010, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
                 5'b01101, 5'b00110, 5'b00111, 5'b01110, 5'b01111, 5'b01001, 5'b01100};
        t_a  = '{32'd5, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h80000000,
                 32'h7FFFFFF0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h12345678, 32'h12345678, 32'd5, 32'd5};
        t_b  = '{32'd7, 32'h21, 32'd1, 32'hFFFFFFFF, 32'd1, 32'hFF00FF00, 32'd4,
                 32'h24, 32'h0F0F0000, 32'hFF00FF00, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'd3, 32'd3};
        t_e  = '{32'hFFFFFFFE, 32'd2, 32'd1, 32'd0, 32'd0, 32'h0FF00FF0, 32'h08000000,
                 32'h07FFFFFF, 32'hFFFFF0F0, 32'hF000F000, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0};
        m_op = '{5'b10000, 5'b11010, 5'b10100, 5'b10111, 5'b10100, 5'b10110, 5'b10100, 5'b10110, 5'b10111};
        m_a  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'd7, 32'h80000000, 32'h80000000,
                 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100};
        m_b  = '{32'd3, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7};
        m_e  = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0,
                 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2};
        m_it = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = '0;
        data_a = '0;
        data_b = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(5'b00000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, "b2b_add", w1);
        issue(5'b01101, 32'h80000000, 32'd4, 32'hF8000000, 1, "b2b_sra", w2);
        issue(5'b00011, 32'd1, 32'hFFFFFFFF, 32'd1, 1, "b2b_sltu", w3);
        chk("b2b_in_ready_waits", w1 + w2 + w3, 0);
        for (int i = 0; i < 14; i++)
            issue(t_op[i], t_a[i], t_b[i], t_e[i], 1, $sformatf("base_%0d", i), wd);
        drain("base");

        busy_cnt = 0;
        issue(5'b10001, 32'hFFFFFFFE, 32'd3, mexp(32'hFFFFFFFF), ILAT, "mulh", wd);
        drain("mulh");
        chk("mulh_busy_cycles", busy_cnt, MD ? 32 : 0);

        for (int i = 0; i < 9; i++)
            issue(m_op[i], m_a[i], m_b[i], mexp(m_e[i]), m_it[i] ? ILAT : 1,
                  $sformatf("mop_%0d", i), wd);
        drain("mops");

        out_ready = 1'b0;
        issue(5'b10101, 32'd100, 32'd7, mexp(32'd14), ILAT, "bp_divu", wd);
        fork
            issue(5'b00000, 32'd3, 32'd4, 32'd7, 1, "bp_add", wd);
            begin
                int w = 0;
                #1;
                while (!out_valid && w < 100) begin
                    @(negedge clk);
                    #1;
                    w++;
                end
                chk("bp_out_valid", out_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) #1;
                    chk($sformatf("bp_hold_result_%0d", i), result, mexp(32'd14));
                    chk($sformatf("bp_hold_in_ready_%0d", i), in_ready, 0);
                    @(negedge clk);
                end
                out_ready = 1'b1;
                #1;
                chk("bp_release_in_ready", in_ready, 1);
            end
        join
        drain("bp");

        issue(5'b10101, 32'd1000, 32'd3, mexp(32'd333), ILAT, "divu_aborted", wd);
        repeat (9) @(negedge clk);
        #1;
        chk("busy_before_reset", busy, MD);
        rst_n = 1'b0;
        val_q.delete();
        lat_q.delete();
        acc_q.delete();
        name_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, mexp(32'hFFFFFFFE), ILAT, "mulhu_after_rst", wd);
        drain("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Registers all base ALU operations with 1-cycle latency.
- Adds the RV32M multiply/divide family, computed iteratively (radix-2, one bit per cycle).
- Sits in the execute stage. The pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a power of two and at least 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- op  input  5  operation select (encoding below)
- data_a  input  WIDTH  operand A (rs1)
- data_b  input  WIDTH  operand B (rs2 or immediate)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result; stable while out_valid && !out_ready
- busy  output  1  multi-cycle multiply/divide in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values:
  - state = IDLE, out_valid = 0, result = 0, busy = 0.
  - in_ready = 1 after reset.
  - Iteration counter and accumulators are cleared.
- Base op encoding (op[4] = 0):
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU.
  - 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - 1110 SEL_A, 1111 SEL_B.
  - Codes 1001–1100 are undefined and return 0.
- Base op arithmetic:
  - Shifts use data_b[SHW-1:0] only.
  - SLT/SLTU return 1 or 0, zero-extended.
  - ADD/SUB wrap modulo 2^WIDTH.
- M op encoding (op[4] = 1): op[2:0] = 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. op[3] is ignored.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Result transfer occurs when out_valid && out_ready.
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - When a transfer and an accept happen in the same cycle, both occur. The new op enters its next state with no bubble.
- State machine:
  - IDLE:
    - Base-op accept → DONE next cycle with result loaded (latency 1).
    - Multiply accept → MUL. Divide accept → DIV. Operands are latched in both cases.
  - MUL:
    - Shift-add on operand magnitudes for exactly WIDTH cycles; busy = 1.
    - Then the 2·WIDTH product is negated if the operand signs differ.
    - Signedness: MULH treats both operands as signed; MULHSU treats A signed, B unsigned; MUL and MULHU treat both as unsigned.
    - MUL returns the low WIDTH bits; MULH, MULHSU and MULHU return the high WIDTH bits.
    - → DONE.
  - DIV:
    - Restoring division on magnitudes for exactly WIDTH cycles; busy = 1.
    - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A), for signed ops only.
    - → DONE.
  - DONE:
    - out_valid = 1; result is held.
    - On out_ready: → IDLE, or take the new accept directly.
  - Total latency for M ops: WIDTH+1 cycles from accept to out_valid.
- Divide boundary cases. These are detected at accept; the block goes straight to DONE with latency 1 and does not iterate.
  - Divisor 0: DIV/DIVU return all-ones; REM/REMU return data_a.
  - Signed overflow (data_a = 1 followed by zeros, data_b = all-ones): DIV returns data_a; REM returns 0.
- Operand independence: data_a, data_b and op are don't-care except in the accept cycle.
- Reset mid-operation: asserting rst_n low at any point aborts the iteration immediately and returns all outputs to their reset values. No partial result is ever presented.

Optional Feature:
- Macro: SEQ_ALU_MULDIV_EN.
- Defined: M ops behave as specified above.
- Undefined:
  - MUL/DIV datapath, counter and MUL/DIV states are not instantiated.
  - Any op with op[4] = 1 completes like a base op: latency 1, result = 0.
  - busy is tied to 0.

Test Plan:
- Back-to-back base ops with out_ready held at 1:
  - Stimulus: ADD 0x7FFFFFFF + 1, then SRA 0x80000000 >>> 4, then SLTU 1 < 0xFFFFFFFF.
  - Required: results 0x80000000, 0xF8000000, 1 on consecutive cycles; in_ready never drops.
- Signed multiply high:
  - Stimulus: MULH with -2 (0xFFFFFFFE) × 3.
  - Required: result 0xFFFFFFFF after 33 cycles; busy high for 32 cycles.
  - Stimulus: MUL with the same operands.
  - Required: result 0xFFFFFFFA.
- Divide corner cases, each with latency 1:
  - DIV 7 / 0 → 0xFFFFFFFF.
  - REMU 7 / 0 → 7.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Signed divide rounding:
  - DIV -7 / 2 → 0xFFFFFFFD (-3).
  - REM -7 / 2 → 0xFFFFFFFF (-1).
- Backpressure:
  - Stimulus: hold out_ready = 0 for 5 cycles after out_valid rises on DIVU 100 / 7.
  - Required: result stays at 14, in_ready = 0 throughout. On release, a queued ADD is accepted in the same cycle and its result appears the next cycle.
- Reset mid-division:
  - Stimulus: pull rst_n low 10 cycles into a DIVU.
  - Required: out_valid = 0, busy = 0 and in_ready = 1 immediately. The next op, MULHU 0xFFFFFFFF × 0xFFFFFFFF, returns 0xFFFFFFFE.
